axi_mst_rd_ctrl: RTL

- Single-ID AXI4 read master that converts a simple request (address, beat count) into one INCR burst on AR.
- Collects the R beats into a small response FIFO and presents them on a valid/ready stream.
- Sits directly upstream of the AXI read-only memory slave (AR/R channels) and feeds its AR channel.
- Serves fetch/load clients.

---
 rtl/axi_mst_rd_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/axi_mst_rd_ctrl.sv
// Single-ID AXI4 read master: turns one client request into one INCR burst on AR
// and streams the returned R beats to the client through a small response FIFO.
module axi_mst_rd_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int ID_W       = 4,
   parameter int LEN_W      = 8,
   parameter int MST_ID     = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              rsp_err,
   output logic              axi_mst_arvalid,
   input  logic              axi_mst_arready,
   output logic [ID_W-1:0]   axi_mst_arid,
   output logic [ADDR_W-1:0] axi_mst_araddr,
   output logic [LEN_W-1:0]  axi_mst_arlen,
   output logic [2:0]        axi_mst_arsize,
   output logic [1:0]        axi_mst_arburst,
   output logic              axi_mst_arlock,
   output logic [3:0]        axi_mst_arcache,
   output logic [2:0]        axi_mst_arprot,
   output logic [3:0]        axi_mst_arqos,
   output logic [3:0]        axi_mst_arregion,
   input  logic              axi_mst_rvalid,
   output logic              axi_mst_rready,
   input  logic [ID_W-1:0]   axi_mst_rid,
   input  logic [DATA_W-1:0] axi_mst_rdata,
   input  logic [1:0]        axi_mst_rresp,
   input  logic              axi_mst_rlast
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = DATA_W + 2;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ar_addr_q;
   logic [LEN_W-1:0]  ar_len_q;
   logic [LEN_W:0]    beat_cnt;
   logic              err_acc;

   logic [ENT_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  mem_count;

   logic              fifo_full;
   logic              push;
   logic              load_out;
   logic              beat_err;
   logic              acc_err;
   logic              len_hit;
   logic              beat_final;
   logic              push_err;
   logic              addr_lo_unused;

   // Occupancy counts the presented output entry too, so capacity is exactly FIFO_DEPTH.
   assign fifo_full  = (mem_count + CNT_W'(rsp_valid)) == CNT_W'(FIFO_DEPTH);
   assign push       = axi_mst_rvalid && axi_mst_rready;
   assign load_out   = (mem_count != '0) && (!rsp_valid || rsp_ready);
   assign beat_err   = (axi_mst_rresp != 2'b00) || (axi_mst_rid != ID_W'(MST_ID));
   assign acc_err    = err_acc || beat_err;
   assign len_hit    = beat_cnt == {1'b0, ar_len_q};
   assign beat_final = axi_mst_rlast || len_hit;
   // A final beat is in error if any beat failed or rlast disagrees with the length.
   assign push_err   = beat_final && (acc_err || (axi_mst_rlast != len_hit));

   assign addr_lo_unused = ^req_addr[1:0];

   assign req_ready        = (state == IDLE) && !rst;
   assign axi_mst_arvalid  = (state == ADDR);
   assign axi_mst_rready   = (state == DATA) && !fifo_full;
   assign axi_mst_arid     = ID_W'(MST_ID);
   assign axi_mst_araddr   = ar_addr_q;
   assign axi_mst_arlen    = ar_len_q;
   assign axi_mst_arsize   = 3'b010;
   assign axi_mst_arburst  = 2'b01;
   assign axi_mst_arlock   = 1'b0;
   assign axi_mst_arcache  = 4'd0;
   assign axi_mst_arprot   = 3'd0;
   assign axi_mst_arqos    = 4'd0;
   assign axi_mst_arregion = 4'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ar_addr_q <= '0;
         ar_len_q  <= '0;
         beat_cnt  <= '0;
         err_acc   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  ar_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                  ar_len_q  <= req_len;
                  beat_cnt  <= '0;
                  err_acc   <= 1'b0;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (axi_mst_arready) state <= DATA;
            end
            DATA: begin
               if (push) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  err_acc  <= acc_err;
                  if (beat_final) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {axi_mst_rdata, beat_final, push_err};
   end

   // Entries reach the output register one cycle after being written to storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_count <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_last  <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load_out) rd_ptr <= rd_ptr + 1'b1;
         case ({push, load_out})
            2'b10:   mem_count <= mem_count + 1'b1;
            2'b01:   mem_count <= mem_count - 1'b1;
            default: mem_count <= mem_count;
         endcase
         if (load_out) begin
            rsp_valid                     <= 1'b1;
            {rsp_data, rsp_last, rsp_err} <= mem[rd_ptr];
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule
